// File: rtl/way_rd_arb_pkg.sv
// -----------------------------------------------------------------------------
// way_rd_arb_pkg
// Shared types and helpers for the way-data read arbiter.
//   way_rd_arb_state_e : IDLE / READ / RESP sequencing of one way read.
//   onehot_from_idx    : binary way index -> one-hot vector, all-zeros when the
//                        index is outside the first n ways.
// -----------------------------------------------------------------------------
package way_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } way_rd_arb_state_e;

  // The helper returns a fixed-width vector; callers size-cast it down to
  // their own way count.
  localparam int unsigned ONEHOT_MAX   = 256;
  localparam int          ONEHOT_IDX_W = 8;

  function automatic logic [ONEHOT_MAX-1:0] onehot_from_idx(
    input int unsigned idx,
    input int unsigned n
  );
    logic [ONEHOT_MAX-1:0] vec;
    vec = '0;
    if ((idx < n) && (idx < ONEHOT_MAX)) begin
      vec[idx[ONEHOT_IDX_W-1:0]] = 1'b1;
    end
    return vec;
  endfunction

endpackage

// File: rtl/way_read_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Scans req starting at ptr and
// wrapping modulo NUM_REQ; the first set bit wins.
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    highest-priority requester index
//   grant out NUM_REQ  one-hot grant, zero when no request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/way_read_arbiter.sv
// -----------------------------------------------------------------------------
// way_read_arbiter
// Shares the single way-data read port of the cache data array between
// NUM_REQ requesters. Round-robin accept over a valid/ready request channel,
// one cycle of one-hot target_way, captured data returned over a valid/ready
// response channel. One read in flight at a time (minimum 3 cycles per read).
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    in  NUM_REQ            per-requester read request
//   req_way      in  NUM_REQ*WAY_IDX_W  binary way index per requester
//   req_ready    out NUM_REQ            one-hot accept (IDLE only)
//   rsp_valid    out NUM_REQ            one-hot response valid
//   rsp_ready    in  NUM_REQ            per-requester response accept
//   rsp_data     out DATA_WIDTH         captured way data (shared)
//   rsp_err      out 1                  way index was >= NUM_WAYS
//   target_way   out NUM_WAYS           to WayDataReaderInterface targetWay
//   way_data     in  DATA_WIDTH         from WayDataReaderInterface dataOut
//
// Optional build macro WAY_RD_ARB_PERF_EN adds:
//   perf_stall_cnt out 32           saturating count of cycles with a
//                                   pending-but-not-accepted request
//   perf_grant_cnt out NUM_REQ*16   per-requester wrapping accept counters
// -----------------------------------------------------------------------------
module way_read_arbiter
  import way_rd_arb_pkg::*;
#(
  parameter int NUM_WAYS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3,
  parameter int WAY_IDX_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WAY_IDX_W-1:0]  req_way,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic [NUM_WAYS-1:0]           target_way,
  input  logic [DATA_WIDTH-1:0]         way_data
`ifdef WAY_RD_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt,
  output logic [NUM_REQ*16-1:0]         perf_grant_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  way_rd_arb_state_e    state, stateNext;
  logic [PTR_W-1:0]     rrPtr;
  logic [PTR_W-1:0]     grantId;
  logic [PTR_W-1:0]     winId;
  logic [PTR_W-1:0]     ptrNext;
  logic [NUM_REQ-1:0]   arbGrant;
  logic [WAY_IDX_W-1:0] reqWaySel;
  logic [NUM_WAYS-1:0]  wayOneHot;
  logic                 errQ;
  logic                 accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rrPtr),
    .grant (arbGrant)
  );

  // Winner index and its way index, decoded from the one-hot grant.
  always_comb begin
    winId     = '0;
    reqWaySel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arbGrant[i]) begin
        winId     = PTR_W'(i);
        reqWaySel = req_way[i*WAY_IDX_W +: WAY_IDX_W];
      end
    end
  end

  // An out-of-range index yields an all-zero one-hot, which doubles as the
  // error flag.
  assign wayOneHot = NUM_WAYS'(onehot_from_idx(32'(reqWaySel), NUM_WAYS));

  // Rotate priority to the requester after the winner; wraps to 0, and stays
  // at 0 when there is a single requester.
  assign ptrNext = (winId == PTR_W'(NUM_REQ - 1)) ? '0 : winId + PTR_W'(1);

  assign accept = (state == IDLE) && (|req_valid);

  // Masked during reset so no requester sees a handshake that the next edge
  // will not honour.
  assign req_ready = ((state == IDLE) && rst_n) ? arbGrant : '0;

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = READ;
      READ:    stateNext = RESP;
      RESP:    if (rsp_ready[grantId]) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: reset is synchronous -- it is sampled on the clock edge like any
  // other input, so it sits inside the posedge-only sensitivity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_way <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rrPtr      <= '0;
      grantId    <= '0;
      errQ       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grantId    <= winId;
            rrPtr      <= ptrNext;
            target_way <= wayOneHot;
            errQ       <= ~|wayOneHot;
          end
        end
        READ: begin
          // target_way has been stable for this whole cycle; sample now.
          rsp_data   <= errQ ? '0 : way_data;
          rsp_err    <= errQ;
          rsp_valid  <= NUM_REQ'(1) << grantId;
          target_way <= '0;
        end
        RESP: begin
          if (rsp_ready[grantId]) begin
            rsp_valid <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WAY_RD_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_grant_cnt <= '0;
    end else begin
      if ((|(req_valid & ~req_ready)) && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (accept) begin
        perf_grant_cnt[int'(winId)*16 +: 16] <= perf_grant_cnt[int'(winId)*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_way_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_way_read_arbiter
// Directed bench for way_read_arbiter. Two instances share all inputs:
// dut (NUM_WAYS=4) for the main checks and dut3 (NUM_WAYS=3) so that way
// index 3 is out of range. Inputs change and outputs are sampled 1 ns after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_way_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [5:0]  req_way;
  logic [2:0]  rsp_ready;
  logic [31:0] way_data;

  logic [2:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  target_way;

  logic [2:0]  req_ready3, rsp_valid3;
  logic [31:0] rsp_data3;
  logic        rsp_err3;
  logic [2:0]  target_way3;

`ifdef WAY_RD_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_stall_cnt3;
  logic [47:0] perf_grant_cnt, perf_grant_cnt3;
`endif

  int checks = 0;
  int errors = 0;

  way_read_arbiter #(
    .NUM_WAYS(4), .DATA_WIDTH(32), .NUM_REQ(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_way(req_way), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .target_way(target_way), .way_data(way_data)
`ifdef WAY_RD_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_grant_cnt(perf_grant_cnt)
`endif
  );

  way_read_arbiter #(
    .NUM_WAYS(3), .DATA_WIDTH(32), .NUM_REQ(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_way(req_way), .req_ready(req_ready3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3),
    .rsp_err(rsp_err3), .target_way(target_way3), .way_data(way_data)
`ifdef WAY_RD_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt3), .perf_grant_cnt(perf_grant_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety net: the directed sequence is fixed-length, this only fires if the
  // simulation stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  expTw [3];
    logic [31:0] d;

    expTw[0] = 4'b0001;
    expTw[1] = 4'b0010;
    expTw[2] = 4'b1000;

    // ---- Reset held 3 cycles with all requesters valid ----
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_way   = {2'd3, 2'd1, 2'd0};
    rsp_ready = 3'b000;
    way_data  = 32'h0;
    tick(); tick(); tick();
    check("rst_target_way", 64'(target_way), 64'h0);
    check("rst_rsp_valid",  64'(rsp_valid),  64'h0);
    check("rst_rsp_data",   64'(rsp_data),   64'h0);
    check("rst_rsp_err",    64'(rsp_err),    64'h0);
    check("rst_req_ready",  64'(req_ready),  64'h0);

    rst_n = 1'b1;
    #1;
    check("post_rst_first_grant", 64'(req_ready), 64'b001);
`ifdef WAY_RD_ARB_PERF_EN
    check("post_rst_perf_stall", 64'(perf_stall_cnt), 64'h0);
    check("post_rst_perf_grant", 64'(perf_grant_cnt), 64'h0);
`endif

    // ---- Fairness: all valid, responses always accepted ----
    rsp_ready = 3'b111;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("fair%0d_req_ready", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
      tick();                                   // READ
      d = 32'h1000_0000 + 32'(k);
      way_data = d;
      check($sformatf("fair%0d_ready_low", k), 64'(req_ready), 64'h0);
      check($sformatf("fair%0d_target", k), 64'(target_way), 64'(expTw[k % 3]));
      tick();                                   // RESP
      check($sformatf("fair%0d_rsp_valid", k), 64'(rsp_valid), 64'(3'b001 << (k % 3)));
      check($sformatf("fair%0d_rsp_data", k), 64'(rsp_data), 64'(d));
      tick();                                   // back to IDLE
    end

    // ---- Single read: requester 1, way 2 ----
    req_valid = 3'b010;
    req_way   = {2'd0, 2'd2, 2'd0};
    rsp_ready = 3'b000;
    #1;
    check("single_req_ready", 64'(req_ready), 64'b010);
    tick();                                     // T+1
    req_valid = 3'b000;
    way_data  = 32'hDEAD_BEEF;
    check("single_target_T1", 64'(target_way), 64'b0100);
    check("single_no_rsp_T1", 64'(rsp_valid), 64'h0);
    tick();                                     // T+2
    way_data = 32'h0;
    check("single_target_T2", 64'(target_way), 64'h0);
    check("single_rsp_valid", 64'(rsp_valid), 64'b010);
    check("single_rsp_data",  64'(rsp_data),  64'hDEAD_BEEF);
    check("single_rsp_err",   64'(rsp_err),   64'h0);
    rsp_ready = 3'b010;
    tick();
    check("single_rsp_drop", 64'(rsp_valid), 64'h0);

    // ---- Backpressure on requester 0 (pointer now at 2) ----
    req_valid = 3'b001;
    req_way   = {2'd0, 2'd3, 2'd1};
    rsp_ready = 3'b000;
    #1;
    check("bp_req_ready", 64'(req_ready), 64'b001);
    tick();                                     // READ
    req_valid = 3'b110;
    way_data  = 32'h5A5A_0001;
    tick();                                     // RESP
    way_data  = 32'h1234_5678;
    rsp_ready = 3'b110;                         // non-granted ready is ignored
    check("bp_rsp_valid_first", 64'(rsp_valid), 64'b001);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp%0d_rsp_valid", c), 64'(rsp_valid), 64'b001);
      check($sformatf("bp%0d_rsp_data", c),  64'(rsp_data),  64'h5A5A_0001);
      check($sformatf("bp%0d_req_ready", c), 64'(req_ready), 64'h0);
    end
    rsp_ready = 3'b001;
    tick();                                     // IDLE
    check("bp_release_valid", 64'(rsp_valid), 64'h0);
    check("bp_release_grant", 64'(req_ready), 64'b010);

    // ---- Way 3 from requester 1: in range for dut, out of range for dut3 ----
    rsp_ready = 3'b000;
    tick();                                     // READ
    req_valid = 3'b000;
    way_data  = 32'hFFFF_0000;
    check("oor_target_in_range", 64'(target_way),  64'b1000);
    check("oor_target_zero",     64'(target_way3), 64'h0);
    tick();                                     // RESP
    check("oor_rsp_valid", 64'(rsp_valid3), 64'b010);
    check("oor_rsp_err",   64'(rsp_err3),   64'h1);
    check("oor_rsp_data",  64'(rsp_data3),  64'h0);
    check("inr_rsp_err",   64'(rsp_err),    64'h0);
    check("inr_rsp_data",  64'(rsp_data),   64'hFFFF_0000);
    rsp_ready = 3'b010;
    tick();
    check("oor_rsp_drop", 64'(rsp_valid3), 64'h0);

    // ---- Reset while in RESP (pointer now at 2) ----
    req_valid = 3'b100;
    req_way   = {2'd0, 2'd0, 2'd0};
    rsp_ready = 3'b000;
    way_data  = 32'hCAFE_0003;
    #1;
    check("rr_req_ready", 64'(req_ready), 64'b100);
    tick();                                     // READ
    req_valid = 3'b000;
    tick();                                     // RESP
    check("rr_rsp_valid_before", 64'(rsp_valid), 64'b100);
    rst_n = 1'b0;
    tick();
    check("rr_rsp_valid_after", 64'(rsp_valid), 64'h0);
    check("rr_rsp_data_after",  64'(rsp_data),  64'h0);
    check("rr_target_after",    64'(target_way), 64'h0);
    rst_n     = 1'b1;
    req_valid = 3'b111;
    #1;
    check("rr_ptr_reset", 64'(req_ready), 64'b001);
    tick();
    check("rr_no_stale_rsp", 64'(rsp_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
